// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then map the offset back to a requester index.
module fifo_wr_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   off;
    logic [IW:0]     sum;

    // Rotate, priority-encode from the lowest bit, and wrap the index modulo NREQ.
    always_comb begin
        rot     = NREQ'({req_i, req_i} >> rr_ptr_i);
        found_o = 1'b0;
        off     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found_o = 1'b1;
                off     = IW'(j);
            end
        end
        sum = {1'b0, rr_ptr_i} + {1'b0, off};
        if (sum >= (IW + 1)'(NREQ)) begin
            sum = sum - (IW + 1)'(NREQ);
        end
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter in front of the CDC FIFO: round-robin between requesters
// with a burst lock of up to BURST consecutive words per grant.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int BURST    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic                     wfull,
    output logic [NREQ-1:0]          gnt,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     locked
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          keep;
    logic          accept;
    logic [IW-1:0] cand;
    logic [CW-1:0] cnt_use;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    fifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    // Candidate choice, accept decision and next-state for pointer/lock/count.
    always_comb begin
        keep     = locked_q && req[owner_q];
        cand     = keep ? owner_q : pick_idx;
        accept   = (keep || pick_found) && !wfull && rst_n;
        gnt      = accept ? (NREQ'(1) << cand) : '0;
        winc     = accept;
        // A new burst always starts counting from zero, even when it begins
        // in the same cycle that the previous owner's lock is dropped.
        cnt_use  = keep ? cnt_q : '0;

        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;

        if (locked_q && !req[owner_q]) begin
            locked_d = 1'b0;
            cnt_d    = '0;
            rr_ptr_d = wrap_inc(owner_q);
        end

        if (accept) begin
            owner_d = cand;
            if (cnt_use == CW'(BURST - 1)) begin
                locked_d = 1'b0;
                cnt_d    = '0;
                rr_ptr_d = wrap_inc(cand);
            end else begin
                locked_d = 1'b1;
                cnt_d    = cnt_use + 1'b1;
            end
        end
    end

    // Data mux: one-hot gnt selects the slice, zero when nothing is written.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wdata = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    assign owner  = owner_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: instance 0 with BURST=4, instance 1 with BURST=1,
// both compared every cycle against a behavioural model of the grant rules.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req   [2];
    logic [31:0] rdata [2];
    logic        wfull [2];
    logic [3:0]  gnt   [2];
    logic        winc  [2];
    logic [7:0]  wdata [2];
    logic [1:0]  owner [2];
    logic        locked[2];

    int checks   = 0;
    int failures = 0;

    int   b_len [2] = '{4, 1};
    int   m_rr  [2];
    int   m_own [2];
    int   m_used[2];
    bit   m_lock[2];
    int   n_rr  [2];
    int   n_own [2];
    int   n_used[2];
    bit   n_lock[2];
    logic [3:0] e_gnt[2];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .BURST(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .req_data(rdata[0]), .wfull(wfull[0]),
        .gnt(gnt[0]), .winc(winc[0]), .wdata(wdata[0]), .owner(owner[0]), .locked(locked[0])
    );

    fifo_wr_arbiter #(.NREQ(4), .DATASIZE(8), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .req_data(rdata[1]), .wfull(wfull[1]),
        .gnt(gnt[1]), .winc(winc[1]), .wdata(wdata[1]), .owner(owner[1]), .locked(locked[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_rr[d] = 0; m_own[d] = 0; m_used[d] = 0; m_lock[d] = 1'b0;
        end
    endtask

    // One clock: check combinational and registered outputs mid-cycle, then
    // advance the model on the rising edge. Optional literal expectations pin
    // the model on the directed scenarios.
    task automatic step(input int lg0 = -1, input int ll0 = -1, input int lg1 = -1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int  cand;
            bit  hold;
            bit  acc;
            int  used;
            cand = -1;
            hold = m_lock[d] && req[d][m_own[d]];
            if (hold) cand = m_own[d];
            else begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_rr[d] + k) % 4;
                    if (cand < 0 && req[d][idx]) cand = idx;
                end
            end
            acc = (cand >= 0) && !wfull[d] && rst_n;
            e_gnt[d] = acc ? 4'(1 << cand) : 4'd0;

            chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(e_gnt[d]));
            chk($sformatf("winc%0d", d), 32'(winc[d]), 32'(acc));
            chk($sformatf("wdata%0d", d), 32'(wdata[d]),
                acc ? 32'((rdata[d] >> (cand * 8)) & 32'hff) : 32'd0);
            chk($sformatf("owner%0d", d), 32'(owner[d]), 32'(m_own[d]));
            chk($sformatf("locked%0d", d), 32'(locked[d]), 32'(m_lock[d]));

            n_rr[d] = m_rr[d]; n_own[d] = m_own[d]; n_used[d] = m_used[d]; n_lock[d] = m_lock[d];
            if (m_lock[d] && !req[d][m_own[d]]) begin
                n_lock[d] = 1'b0; n_used[d] = 0; n_rr[d] = (m_own[d] + 1) % 4;
            end
            if (acc) begin
                used = hold ? m_used[d] + 1 : 1;
                n_own[d] = cand;
                if (used == b_len[d]) begin
                    n_lock[d] = 1'b0; n_used[d] = 0; n_rr[d] = (cand + 1) % 4;
                end else begin
                    n_lock[d] = 1'b1; n_used[d] = used;
                end
            end
        end
        if (lg0 >= 0) chk("lit_gnt0", 32'(gnt[0]), 32'(lg0));
        if (ll0 >= 0) chk("lit_locked0", 32'(locked[0]), 32'(ll0));
        if (lg1 >= 0) chk("lit_gnt1", 32'(gnt[1]), 32'(lg1));
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                m_rr[d] = n_rr[d]; m_own[d] = n_own[d]; m_used[d] = n_used[d]; m_lock[d] = n_lock[d];
            end
        end
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        step(0);
        step(0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 4'd0; rdata[d] = $urandom; wfull[d] = 1'b0;
        end
        model_clear();
        step(0, 0);
        chk("rst_owner0", 32'(owner[0]), 32'd0);
        rst_n = 1'b1;

        // Single active requester streams with no gap.
        req[0] = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            rdata[0][15:8] = 8'(8'h30 + k);
            step(4'b0010);
        end
        req[0] = 4'b0000;
        step(0);

        // Two requesters alternate in bursts of four.
        do_reset();
        rdata[0] = $urandom;
        req[0] = 4'b0101;
        for (int k = 0; k < 16; k++) begin
            step(((k / 4) % 2 == 0) ? 4'b0001 : 4'b0100, (k % 4 != 0) ? 1 : 0);
        end
        req[0] = 4'b0000;
        step(0);

        // A full FIFO stalls the burst; remaining quota then completes.
        do_reset();
        req[0] = 4'b1000;
        step(4'b1000);
        step(4'b1000);
        wfull[0] = 1'b1;
        step(0); step(0); step(0);
        wfull[0] = 1'b0;
        step(4'b1000, 1);
        step(4'b1000, 1);
        req[0] = 4'b1001;
        step(4'b0001, 0);
        req[0] = 4'b0000;
        step(0);

        // Owner drops its request mid-burst; another requester wins that cycle.
        do_reset();
        req[0] = 4'b0001;
        step(4'b0001);
        req[0] = 4'b0100;
        step(4'b0100, 1);
        chk("lit_owner_after_drop", 32'(owner[0]), 32'd2);
        req[0] = 4'b0000;
        step(0);

        // Reset in the middle of a burst restarts from requester 0 with a full quota.
        do_reset();
        req[0] = 4'b1111;
        step(4'b0001);
        step(4'b0001);
        do_reset();
        for (int k = 0; k < 4; k++) step(4'b0001);
        step(4'b0010);
        req[0] = 4'b0000;

        // BURST=1 rotates every cycle and never locks.
        do_reset();
        req[1] = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(-1, -1, 1 << (k % 4));
            chk("lit_locked1", 32'(locked[1]), 32'd0);
        end
        req[1] = 4'b0000;
        step();

        // Randomised traffic honouring the hold-until-grant contract, with
        // occasional early drops and random back-pressure.
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) begin
                    if (e_gnt[d][i] || !req[d][i]) begin
                        req[d][i] = ($urandom_range(99) < 60);
                        rdata[d][i*8 +: 8] = 8'($urandom);
                    end else if ($urandom_range(99) < 3) begin
                        req[d][i] = 1'b0;
                    end
                end
                wfull[d] = ($urandom_range(99) < 25);
            end
            if (n == 1500) begin
                rst_n = 1'b0;
                model_clear();
                step();
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
